fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_perf_cnt.sv | 35 +++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2,
    F_KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: delivered instructions and discarded responses.
// Instantiated by fetch_stage only when FETCH_PERF_EN is defined.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc_fetched,
  input  logic        i_inc_killed,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_killed
);

  logic [31:0] r_fetched;
  logic [31:0] r_killed;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetched <= 32'h0000_0000;
      r_killed  <= 32'h0000_0000;
    end else begin
      if (i_inc_fetched) begin
        r_fetched <= r_fetched + 32'd1;
      end
      if (i_inc_killed) begin
        r_killed <= r_killed + 32'd1;
      end
    end
  end

  assign o_perf_fetched = r_fetched;
  assign o_perf_killed  = r_killed;

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding-request instruction fetch with stall hold and branch redirect.
// Define FETCH_PERF_EN to build the fetched/killed performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        fetch_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
);

  fetch_state_e state_q;
  fetch_state_e w_state_d;
  logic [31:0]  pc_q;
  logic [31:0]  w_pc_d;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_inst;
  logic         w_hold_ld;
  logic         w_req;
  logic         w_valid;
  logic [31:0]  w_out_pc;
  logic [31:0]  w_out_inst;

  // Next-state, next-pc and handoff decode; br_taken overrides every other event.
  always_comb begin
    w_state_d  = state_q;
    w_pc_d     = pc_q;
    w_hold_ld  = 1'b0;
    w_req      = 1'b0;
    w_valid    = 1'b0;
    w_out_pc   = 32'h0000_0000;
    w_out_inst = BUBBLE_INST;
    case (state_q)
      F_REQ: begin
        if (br_taken) begin
          w_pc_d    = word_align(br_target);
          w_state_d = F_REQ;
        end else begin
          w_req = 1'b1;
          if (imem_gnt) begin
            w_state_d = F_WAIT;
          end else begin
            w_state_d = F_REQ;
          end
        end
      end
      F_WAIT: begin
        if (br_taken) begin
          w_pc_d = word_align(br_target);
          if (imem_rvalid) begin
            w_state_d = F_REQ;
          end else begin
            w_state_d = F_KILL;
          end
        end else if (imem_rvalid) begin
          if (stall) begin
            w_hold_ld = 1'b1;
            w_state_d = F_HOLD;
          end else begin
            w_valid    = 1'b1;
            w_out_pc   = pc_q;
            w_out_inst = imem_rdata;
            w_pc_d     = pc_q + PC_STEP;
            w_state_d  = F_REQ;
          end
        end else begin
          w_state_d = F_WAIT;
        end
      end
      F_HOLD: begin
        if (br_taken) begin
          w_pc_d    = word_align(br_target);
          w_state_d = F_REQ;
        end else if (!stall) begin
          w_valid    = 1'b1;
          w_out_pc   = hold_pc;
          w_out_inst = hold_inst;
          w_pc_d     = pc_q + PC_STEP;
          w_state_d  = F_REQ;
        end else begin
          w_state_d = F_HOLD;
        end
      end
      F_KILL: begin
        // A response landing with a fresh redirect retires the only outstanding
        // request, so there is nothing left to wait for.
        if (br_taken) begin
          w_pc_d = word_align(br_target);
        end else begin
          w_pc_d = pc_q;
        end
        if (imem_rvalid) begin
          w_state_d = F_REQ;
        end else begin
          w_state_d = F_KILL;
        end
      end
      default: begin
        w_state_d = F_REQ;
      end
    endcase
  end

  // FSM state, fetch address and stalled-response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= F_REQ;
      pc_q      <= RESET_PC;
      hold_pc   <= 32'h0000_0000;
      hold_inst <= 32'h0000_0000;
    end else begin
      state_q <= w_state_d;
      pc_q    <= w_pc_d;
      if (w_hold_ld) begin
        hold_pc   <= pc_q;
        hold_inst <= imem_rdata;
      end
    end
  end

  assign imem_req    = w_req & ~reset;
  assign imem_addr   = pc_q;
  assign fetch_valid = w_valid & ~reset;
  assign pc          = fetch_valid ? w_out_pc : 32'h0000_0000;
  assign inst        = fetch_valid ? w_out_inst : BUBBLE_INST;

`ifdef FETCH_PERF_EN
  logic w_kill;

  assign w_kill = ((state_q == F_KILL) & imem_rvalid)
                | ((state_q == F_WAIT) & br_taken & imem_rvalid)
                | ((state_q == F_HOLD) & br_taken);

  fetch_perf_cnt u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_inc_fetched  (fetch_valid),
    .i_inc_killed   (w_kill),
    .o_perf_fetched (perf_fetched),
    .o_perf_killed  (perf_killed)
  );
`else
  assign perf_fetched = 32'h0000_0000;
  assign perf_killed  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handoff, stall hold, redirects, pc wrap, reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_valid;
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .inst         (inst),
    .fetch_valid  (fetch_valid),
    .perf_fetched (perf_fetched),
    .perf_killed  (perf_killed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic br, input logic [31:0] tgt,
                       input logic g, input logic rv, input logic [31:0] rd);
    stall = s; br_taken = br; br_target = tgt;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    check_eq({tag, "_pc"}, pc, 32'h0);
    check_eq({tag, "_inst"}, inst, 32'h0);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] epc, input logic [31:0] einst);
    check_eq({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    check_eq({tag, "_pc"}, pc, epc);
    check_eq({tag, "_inst"}, inst, einst);
  endtask

  task automatic check_req(input string tag, input logic ereq, input logic [31:0] eaddr);
    check_eq({tag, "_req"}, {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) begin
      check_eq({tag, "_addr"}, imem_addr, eaddr);
    end
  endtask

  task automatic check_perf(input string tag, input logic [31:0] ef, input logic [31:0] ek);
`ifdef FETCH_PERF_EN
    check_eq({tag, "_perf_fetched"}, perf_fetched, ef);
    check_eq({tag, "_perf_killed"}, perf_killed, ek);
`else
    check_eq({tag, "_perf_fetched"}, perf_fetched, 32'h0 & ef);
    check_eq({tag, "_perf_killed"}, perf_killed, 32'h0 & ek);
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    // Reset: bubble, no request.
    check_req("rst", 1'b0, 32'h0);
    check_bubble("rst");
    check_perf("rst", 32'd0, 32'd0);

    // Sequential fetch from RESET_PC, one instruction per two cycles.
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("s1_req0", 1'b1, 32'h0000_0100);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
    check_fetch("s1_f0", 32'h0000_0100, 32'hAAAA_0001);
    check_req("s1_wait0", 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_bubble("s1_gap");
    check_req("s1_req1", 1'b1, 32'h0000_0104);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0002);
    check_fetch("s1_f1", 32'h0000_0104, 32'hAAAA_0002);
    step();

    // Redirect from F_REQ to 0x200, then stall around the response.
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
    check_req("s2_br", 1'b0, 32'h0);
    check_bubble("s2_br");
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("s2_req", 1'b1, 32'h0000_0200);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_bubble("s2_st0");
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    check_bubble("s2_st1");
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    check_bubble("s2_st2");
    check_req("s2_hold", 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_fetch("s2_rel", 32'h0000_0200, 32'h1234_5678);
    step();
    check_bubble("s2_once");
    check_req("s2_next", 1'b1, 32'h0000_0204);
    step();
    check_req("s2_stable", 1'b1, 32'h0000_0204);

    // Redirect while waiting: late response must be discarded.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
    check_bubble("s3_br");
    check_req("s3_br", 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("s3_kill", 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check_bubble("s3_late");
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("s3_next", 1'b1, 32'h0000_0400);
    check_perf("s3", 32'd3, 32'd1);

    // Redirect coincident with response: dropped, no kill cycle.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'h0000_0803, 1'b0, 1'b1, 32'h5555_5555);
    check_bubble("s4_co");
    check_req("s4_co", 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    check_req("s4_next", 1'b1, 32'h0000_0800);
    check_bubble("s4_stray");
    check_perf("s4", 32'd3, 32'd2);
    step();

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_req("s5_req", 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0000);
    check_fetch("s5_f", 32'hFFFF_FFFC, 32'hCAFE_0000);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("s5_wrap", 1'b1, 32'h0000_0000);

    // Reset during F_WAIT: immediate bubble, clean restart at RESET_PC.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_9999);
    reset = 1'b1;
    #1;
    check_bubble("s6_rst");
    check_req("s6_rst", 1'b0, 32'h0);
    check_perf("s6_rst", 32'd0, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_req("s6_first", 1'b1, 32'h0000_0100);
    check_bubble("s6_first");
    check_perf("s6_rel", 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
